// File: rtl/fpadd_arbiter.sv
// Round-robin arbiter sharing one FP32 adder between NUM_REQ valid/ready requesters.
// Optional FPADD_ARB_PRIO0_EN: requester 0 gets strict priority over the round-robin group.
module fpadd_arbiter #(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned ADD_LAT = 2,
    parameter int unsigned TAG_W   = 3
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    en,
    input  logic [NUM_REQ-1:0]      req_valid,
    input  logic [32*NUM_REQ-1:0]   req_a,
    input  logic [32*NUM_REQ-1:0]   req_b,
    output logic [NUM_REQ-1:0]      req_ready,
    output logic [31:0]             add_a,
    output logic [31:0]             add_b,
    input  logic [31:0]             add_result,
    output logic [NUM_REQ-1:0]      rsp_valid,
    output logic [31:0]             rsp_data,
    output logic                    idle
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DRAIN
    } state_t;

    state_t               state, state_nxt;
    logic [TAG_W-1:0]     rr_ptr;
    logic [TAG_W-1:0]     nxt_ptr;
    logic                 upd_ptr;
    logic                 accept;
    logic [TAG_W-1:0]     gidx;
    logic [NUM_REQ-1:0]   grant;
    logic [31:0]          sel_a, sel_b;

    // Stage 0 travels alongside add_a/add_b; the remaining ADD_LAT stages track the adder.
    logic [ADD_LAT:0]     tp_valid;
    logic [TAG_W-1:0]     tp_tag [ADD_LAT+1];
    logic                 pipe_empty;

    assign pipe_empty = ~|tp_valid;
    assign req_ready  = grant;
    assign idle       = (state == S_IDLE) && pipe_empty && ~|rsp_valid;

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (en) state_nxt = S_RUN;
            S_RUN:   if (!en) state_nxt = S_DRAIN;
            S_DRAIN: begin
                if (en)              state_nxt = S_RUN;
                else if (pipe_empty) state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // Pass 0 searches rr_ptr..NUM_REQ-1, pass 1 wraps around from 0.
    always_comb begin
        grant   = '0;
        gidx    = '0;
        accept  = 1'b0;
        upd_ptr = 1'b0;
        nxt_ptr = rr_ptr;
        sel_a   = '0;
        sel_b   = '0;
        if (state == S_RUN) begin
`ifdef FPADD_ARB_PRIO0_EN
            if (req_valid[0]) begin
                grant[0] = 1'b1;
                accept   = 1'b1;
                sel_a    = req_a[31:0];
                sel_b    = req_b[31:0];
            end
`endif
            for (int unsigned pass = 0; pass < 2; pass++) begin
                for (int unsigned i = 0; i < NUM_REQ; i++) begin
                    if (!accept && req_valid[i] && (pass == 1 || i >= 32'(rr_ptr))) begin
                        grant[i] = 1'b1;
                        gidx     = TAG_W'(i);
                        accept   = 1'b1;
                        upd_ptr  = 1'b1;
                        nxt_ptr  = TAG_W'((i + 1) % NUM_REQ);
                        sel_a    = req_a[32*i +: 32];
                        sel_b    = req_b[32*i +: 32];
                    end
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= S_IDLE;
            rr_ptr    <= '0;
            add_a     <= '0;
            add_b     <= '0;
            tp_valid  <= '0;
            rsp_valid <= '0;
            rsp_data  <= '0;
            for (int unsigned k = 0; k <= ADD_LAT; k++) begin
                tp_tag[k] <= '0;
            end
        end else begin
            state <= state_nxt;
            if (accept) begin
                add_a <= sel_a;
                add_b <= sel_b;
                if (upd_ptr) rr_ptr <= nxt_ptr;
            end
            tp_valid  <= {tp_valid[ADD_LAT-1:0], accept};
            tp_tag[0] <= gidx;
            for (int unsigned k = 1; k <= ADD_LAT; k++) begin
                tp_tag[k] <= tp_tag[k-1];
            end
            if (tp_valid[ADD_LAT]) begin
                rsp_valid <= NUM_REQ'(1) << tp_tag[ADD_LAT];
                rsp_data  <= add_result;
            end else begin
                rsp_valid <= '0;
            end
        end
    end

endmodule

// File: tb/tb_fpadd_arbiter.sv
// Scoreboard bench for fpadd_arbiter: directed vectors, expected sums hand-computed,
// a behavioural two-cycle FP32 adder stands in for the shared adder.
module tb_fpadd_arbiter;

    localparam int unsigned N = 4;

    logic              clk;
    logic              reset;
    logic              en;
    logic [N-1:0]      req_valid;
    logic [32*N-1:0]   req_a;
    logic [32*N-1:0]   req_b;
    logic [N-1:0]      req_ready;
    logic [31:0]       add_a;
    logic [31:0]       add_b;
    logic [31:0]       add_result;
    logic [N-1:0]      rsp_valid;
    logic [31:0]       rsp_data;
    logic              idle;

    fpadd_arbiter #(.NUM_REQ(4), .ADD_LAT(2), .TAG_W(3)) dut (
        .clk(clk), .reset(reset), .en(en),
        .req_valid(req_valid), .req_a(req_a), .req_b(req_b), .req_ready(req_ready),
        .add_a(add_a), .add_b(add_b), .add_result(add_result),
        .rsp_valid(rsp_valid), .rsp_data(rsp_data), .idle(idle)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic real f2r(input logic [31:0] x);
        real m;
        int  e;
        if (x[30:0] == 31'd0) return 0.0;
        m = 1.0 + real'(x[22:0]) / 8388608.0;
        e = int'(x[30:23]) - 127;
        while (e > 0) begin m = m * 2.0; e--; end
        while (e < 0) begin m = m / 2.0; e++; end
        return x[31] ? -m : m;
    endfunction

    function automatic logic [31:0] r2f(input real v);
        logic s;
        int   e;
        real  r;
        if (v == 0.0) return 32'h0;
        s = (v < 0.0);
        r = s ? -v : v;
        e = 127;
        while (r >= 2.0 && e < 254) begin r = r / 2.0; e++; end
        while (r < 1.0 && e > 1) begin r = r * 2.0; e--; end
        return {s, 8'(e), 23'($rtoi((r - 1.0) * 8388608.0 + 0.5))};
    endfunction

    // Stand-in adder: operands presented in cycle t appear on add_result in cycle t+2.
    logic [31:0] sum_s1;
    always @(posedge clk) begin
        sum_s1     <= r2f(f2r(add_a) + f2r(add_b));
        add_result <= sum_s1;
    end

    typedef struct {
        logic [N-1:0] v;
        logic [31:0]  d;
        int unsigned  c;
    } exp_t;
    exp_t sbq[$];

    int unsigned checks = 0;
    int unsigned failures = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    always @(negedge clk) begin
        if (rsp_valid !== '0) begin
            if (sbq.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL rsp_unexpected: got rsp_valid %b expected none (cycle %0d)", rsp_valid, cyc);
            end else begin
                exp_t e;
                e = sbq.pop_front();
                check("rsp_valid", 32'(rsp_valid), 32'(e.v));
                check("rsp_data", rsp_data, e.d);
                check("rsp_cycle", cyc, e.c);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_ops(input int unsigned i, input logic [31:0] a, input logic [31:0] b);
        req_a[32*i +: 32] = a;
        req_b[32*i +: 32] = b;
    endtask

    task automatic expect_rsp(input int unsigned i, input logic [31:0] s);
        exp_t e;
        e.v = N'(1) << i;
        e.d = s;
        e.c = cyc + 4;
        sbq.push_back(e);
    endtask

    // Single request from requester i in the current cycle; grant is checked mid-cycle.
    task automatic send(input int unsigned i, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] s);
        req_valid = N'(1) << i;
        set_ops(i, a, b);
        expect_rsp(i, s);
        @(negedge clk);
        check("grant_single", 32'(req_ready), 32'(N'(1) << i));
        step();
        req_valid = '0;
    endtask

    task automatic wait_drain(input int unsigned max_cycles);
        int unsigned n = 0;
        while (sbq.size() != 0 && n < max_cycles) begin
            step();
            n++;
        end
        checks++;
        if (sbq.size() != 0) begin
            failures++;
            $display("FAIL drain_timeout: got %0d pending responses expected 0", sbq.size());
        end
        step();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no completion expected $finish");
        $fatal(1);
    end

    initial begin
        int unsigned c;
        logic [N-1:0] pat_valid [5];
        int unsigned  pat_grant [5];

        reset = 1'b1;
        en = 1'b0;
        req_valid = '0;
        req_a = '0;
        req_b = '0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        req_valid = '1;
        @(negedge clk);
        check("reset_add_a", add_a, 32'h0);
        check("reset_add_b", add_b, 32'h0);
        check("reset_rsp_valid", 32'(rsp_valid), 32'h0);
        check("reset_rsp_data", rsp_data, 32'h0);
        check("reset_idle", 32'(idle), 32'h1);
        check("idle_no_grant", 32'(req_ready), 32'h0);
        step();
        req_valid = '0;
        en = 1'b1;
        step();

        // Single op: 1.0 + 2.0 from requester 2
        send(2, 32'h3F800000, 32'h40000000, 32'h40400000);
        wait_drain(10);

        // Round-robin fairness with all four requesters valid, starting from rr_ptr=0
        reset = 1'b1;
        step();
        reset = 1'b0;
        step();
        set_ops(0, 32'h3FC00000, 32'h40200000);
        set_ops(1, 32'h3F800000, 32'h3F800000);
        set_ops(2, 32'h40A00000, 32'h3F000000);
        set_ops(3, 32'hC0000000, 32'h3F800000);
        req_valid = '1;
        for (int unsigned k = 0; k < 8; k++) begin
            case (k % 4)
                0: expect_rsp(0, 32'h40800000);
                1: expect_rsp(1, 32'h40000000);
                2: expect_rsp(2, 32'h40B00000);
                default: expect_rsp(3, 32'hBF800000);
            endcase
            @(negedge clk);
            check("grant_rr", 32'(req_ready), 32'(N'(1) << (k % 4)));
            step();
        end
        req_valid = '0;
        wait_drain(12);

        // Cancellation: 1.0 + -1.0 from requester 1
        send(1, 32'h3F800000, 32'hBF800000, 32'h00000000);
        wait_drain(10);

        // Drain: three back-to-back ops, en dropped the cycle after the last accept
        send(0, 32'h3F800000, 32'h40000000, 32'h40400000);
        send(1, 32'h40000000, 32'h40000000, 32'h40800000);
        send(2, 32'h3FC00000, 32'h3FC00000, 32'h40400000);
        c = cyc - 1;
        en = 1'b0;
        step();
        req_valid = '1;
        for (int unsigned k = 0; k < 4; k++) begin
            @(negedge clk);
            check("drain_no_grant", 32'(req_ready), 32'h0);
            if (cyc == c + 4) check("drain_idle_busy", 32'(idle), 32'h0);
            if (cyc == c + 5) check("drain_idle_done", 32'(idle), 32'h1);
            step();
        end
        req_valid = '0;
        check("drain_all_rsp", sbq.size(), 32'h0);

        // Reset two cycles after an accept discards the in-flight op
        en = 1'b1;
        step();
        req_valid = 4'b1000;
        set_ops(3, 32'h40400000, 32'h3F800000);
        @(negedge clk);
        check("grant_pre_reset", 32'(req_ready), 32'h8);
        step();
        req_valid = '0;
        step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        @(negedge clk);
        check("midreset_add_a", add_a, 32'h0);
        check("midreset_add_b", add_b, 32'h0);
        check("midreset_rsp_valid", 32'(rsp_valid), 32'h0);
        check("midreset_rsp_data", rsp_data, 32'h0);
        check("midreset_idle", 32'(idle), 32'h1);
        step();
        req_valid = 4'b1000;
        set_ops(3, 32'h40000000, 32'h3F800000);
        expect_rsp(3, 32'h40400000);
        @(negedge clk);
        check("grant_post_reset", 32'(req_ready), 32'h8);
        check("midreset_no_stale_rsp", 32'(rsp_valid), 32'h0);
        step();
        req_valid = '0;
        wait_drain(10);

        // Requesters 0 and 3 contending, then requester 0 drops out
        set_ops(0, 32'h3F800000, 32'h3F800000);
        set_ops(3, 32'hC0000000, 32'h3F800000);
`ifdef FPADD_ARB_PRIO0_EN
        pat_grant[0] = 0; pat_grant[1] = 0; pat_grant[2] = 0; pat_grant[3] = 0;
`else
        pat_grant[0] = 0; pat_grant[1] = 3; pat_grant[2] = 0; pat_grant[3] = 3;
`endif
        pat_grant[4] = 3;
        for (int unsigned k = 0; k < 4; k++) pat_valid[k] = 4'b1001;
        pat_valid[4] = 4'b1000;
        for (int unsigned k = 0; k < 5; k++) begin
            req_valid = pat_valid[k];
            expect_rsp(pat_grant[k], (pat_grant[k] == 0) ? 32'h40000000 : 32'hBF800000);
            @(negedge clk);
            check("grant_contend", 32'(req_ready), 32'(N'(1) << pat_grant[k]));
            step();
        end
        req_valid = '0;
        wait_drain(12);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
